vertex_xform_sequencer: RTL and testbench

Initiator-side controller for the vertex-by-matrix transform unit. It fetches a run of object-space vertices from vertex memory and feeds each one to the transform unit using its start/done handshake. It captures each transformed (x,y,z) result and streams it downstream with a valid/ready handshake. It sits between the vertex buffer and the rasteriser setup stage. The 4x4 matrix bus is driven by the upstream owner and must stay stable while busy=1; this block does not touch it.

---
 rtl/vertex_xform_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_vertex_xform_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_xform_sequencer.sv
// Vertex transform sequencer: fetches a run of vertices, feeds each through the
// transform unit via start/done, and streams transformed results downstream.
`timescale 1ns/1ps
module vertex_xform_sequencer #(
    parameter int unsigned IDX_W   = 16,
    parameter int unsigned TIMEOUT = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [IDX_W-1:0] vtx_base,
    input  logic [IDX_W-1:0] vtx_count,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic             rd_req,
    output logic [IDX_W-1:0] rd_addr,
    input  logic             rd_valid,
    input  logic [31:0]      rd_x,
    input  logic [31:0]      rd_y,
    input  logic [31:0]      rd_z,
    output logic             xf_start,
    output logic [31:0]      xf_x,
    output logic [31:0]      xf_y,
    output logic [31:0]      xf_z,
    input  logic             xf_done,
    input  logic [31:0]      xf_x_out,
    input  logic [31:0]      xf_y_out,
    input  logic [31:0]      xf_z_out,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic [31:0]      o_x,
    output logic [31:0]      o_y,
    output logic [31:0]      o_z
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_RD   = 3'd2;
    localparam logic [2:0] S_KICK      = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_EMIT      = 3'd6;

    // Last allowed count values: done must drop by the second cycle after start.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] BUSY_LAST = TMO_W'(2);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] xf_x_q, xf_x_d, xf_y_q, xf_y_d, xf_z_q, xf_z_d;
    logic [DATA_W-1:0] o_x_q, o_x_d, o_y_q, o_y_d, o_z_q, o_z_d;
    logic [IDX_W-1:0]  o_idx_q, o_idx_d;
    logic              o_valid_q, o_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;
    logic              rd_req_q, rd_req_d;
    logic              xf_start_q, xf_start_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        tmo_d        = tmo_q;
        xf_x_d       = xf_x_q;
        xf_y_d       = xf_y_q;
        xf_z_d       = xf_z_q;
        o_x_d        = o_x_q;
        o_y_d        = o_y_q;
        o_z_d        = o_z_q;
        o_idx_d      = o_idx_q;
        o_valid_d    = o_valid_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        xf_start_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    err_d = 1'b0;
                    cur_d = vtx_base;
                    rem_d = vtx_count;
                    if (vtx_count == '0) frame_done_d = 1'b1;
                    else                 state_d      = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                if (rd_valid) begin
                    xf_x_d  = rd_x;
                    xf_y_d  = rd_y;
                    xf_z_d  = rd_z;
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                // Start only once the unit reports idle.
                if (xf_done) begin
                    xf_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!xf_done) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (xf_done) begin
                    o_x_d     = xf_x_out;
                    o_y_d     = xf_y_out;
                    o_z_d     = xf_z_out;
                    o_idx_d   = cur_q;
                    o_valid_d = 1'b1;
                    state_d   = S_EMIT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    o_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_EMIT: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    cur_d     = cur_q + IDX_W'(1);
                    rem_d     = rem_q - IDX_W'(1);
                    if (rem_q == IDX_W'(1)) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_req_d = (state_d == S_FETCH);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            xf_x_q       <= '0;
            xf_y_q       <= '0;
            xf_z_q       <= '0;
            o_x_q        <= '0;
            o_y_q        <= '0;
            o_z_q        <= '0;
            o_idx_q      <= '0;
            o_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            rd_req_q     <= 1'b0;
            xf_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rem_q        <= rem_d;
            tmo_q        <= tmo_d;
            xf_x_q       <= xf_x_d;
            xf_y_q       <= xf_y_d;
            xf_z_q       <= xf_z_d;
            o_x_q        <= o_x_d;
            o_y_q        <= o_y_d;
            o_z_q        <= o_z_d;
            o_idx_q      <= o_idx_d;
            o_valid_q    <= o_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            rd_req_q     <= rd_req_d;
            xf_start_q   <= xf_start_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = cur_q;
    assign xf_start   = xf_start_q;
    assign xf_x       = xf_x_q;
    assign xf_y       = xf_y_q;
    assign xf_z       = xf_z_q;
    assign o_valid    = o_valid_q;
    assign o_idx      = o_idx_q;
    assign o_x        = o_x_q;
    assign o_y        = o_y_q;
    assign o_z        = o_z_q;

endmodule

// File: tb/tb_vertex_xform_sequencer.sv
// Bench for vertex_xform_sequencer: vertex memory and transform unit models,
// a table of directed frames, and hand sequences for count=0, timeout and reset.
`timescale 1ns/1ps
module tb_vertex_xform_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [15:0] vtx_base = '0;
    logic [15:0] vtx_count = '0;
    logic        busy, frame_done, err, rd_req, xf_start, o_valid;
    logic [15:0] rd_addr, o_idx;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_x = '0, rd_y = '0, rd_z = '0;
    logic [31:0] xf_x, xf_y, xf_z, o_x, o_y, o_z;
    logic        xf_done = 1'b1;
    logic [31:0] xf_x_out = '0, xf_y_out = '0, xf_z_out = '0;
    logic        o_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = '0;
    int          model_t = 62;
    int          model_cnt = 0;
    logic        hang = 1'b0;
    logic        op_track = 1'b0;
    logic [31:0] op_x = '0, op_y = '0, op_z = '0;

    int          rd_cnt = 0, xs_cnt = 0, fd_cnt = 0, start_viol = 0, op_viol = 0;
    logic [15:0] last_rd_addr = '0;

    vertex_xform_sequencer #(.IDX_W(16), .TIMEOUT(128)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .vtx_base(vtx_base), .vtx_count(vtx_count),
        .busy(busy), .frame_done(frame_done), .err(err), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
        .xf_start(xf_start), .xf_x(xf_x), .xf_y(xf_y), .xf_z(xf_z),
        .xf_done(xf_done), .xf_x_out(xf_x_out), .xf_y_out(xf_y_out), .xf_z_out(xf_z_out),
        .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx), .o_x(o_x), .o_y(o_y), .o_z(o_z)
    );

    always #5 clk = ~clk;

    // Vertex memory: lanes are 2.0, 4.0, 8.0 with the index in the low mantissa bits.
    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (rd_req) begin
            if (mem_lat <= 1) begin
                rd_valid <= 1'b1;
                rd_x <= {16'h4000, rd_addr};
                rd_y <= {16'h4080, rd_addr};
                rd_z <= {16'h4100, rd_addr};
            end else begin
                mem_cnt  <= mem_lat - 1;
                mem_addr <= rd_addr;
            end
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                rd_valid <= 1'b1;
                rd_x <= {16'h4000, mem_addr};
                rd_y <= {16'h4080, mem_addr};
                rd_z <= {16'h4100, mem_addr};
            end
        end
    end

    // Transform unit: result = input + 1.0; inside each lane's exponent band
    // that is an exact mantissa add. Not reset by the sequencer.
    always @(posedge clk) begin
        if (!reset_n) op_track <= 1'b0;
        if (xf_done) begin
            if (xf_start) begin
                xf_done   <= 1'b0;
                model_cnt <= model_t;
                xf_x_out  <= xf_x + 32'h0040_0000;
                xf_y_out  <= xf_y + 32'h0020_0000;
                xf_z_out  <= xf_z + 32'h0010_0000;
                op_x      <= xf_x;
                op_y      <= xf_y;
                op_z      <= xf_z;
                op_track  <= reset_n;
            end
        end else if (!hang) begin
            if (model_cnt <= 1) begin
                xf_done  <= 1'b1;
                op_track <= 1'b0;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_req) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= rd_addr;
        end
        if (xf_start) xs_cnt <= xs_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (xf_start && !xf_done) start_viol <= start_viol + 1;
        if (op_track && reset_n && !xf_done && (xf_x !== op_x || xf_y !== op_y || xf_z !== op_z))
            op_viol <= op_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge. Runs one frame and checks every result and the frame-level counts.
    task automatic run_frame(input logic [15:0] base, input logic [15:0] cnt, input int stall,
                             input logic [15:0] exp_last);
        int          rd0, xs0, fd0, cyc, rc;
        logic [15:0] idx, last_idx, sidx;
        logic [31:0] sx, sy, sz;
        logic        stable;
        rd0 = rd_cnt; xs0 = xs_cnt; fd0 = fd_cnt; last_idx = '0;
        go = 1'b1; vtx_base = base; vtx_count = cnt;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < int'(cnt); k++) begin
            idx = base + 16'(k);
            @(negedge clk);
            o_ready = (k == stall) ? 1'b0 : 1'b1;
            cyc = 0;
            while (!o_valid && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            if (!o_valid) begin
                check("o_valid_wait", 32'(o_valid), 32'd1);
                o_ready = 1'b1;
                return;
            end
            check("o_idx", 32'(o_idx), 32'(idx));
            check("o_x", o_x, {16'h4040, idx});
            check("o_y", o_y, {16'h40A0, idx});
            check("o_z", o_z, {16'h4110, idx});
            check("rd_addr", 32'(last_rd_addr), 32'(idx));
            last_idx = o_idx;
            if (k == stall) begin
                sx = o_x; sy = o_y; sz = o_z; sidx = o_idx; rc = rd_cnt; stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (!o_valid || o_x !== sx || o_y !== sy || o_z !== sz || o_idx !== sidx)
                        stable = 1'b0;
                end
                check("bp_stable", 32'(stable), 32'd1);
                check("bp_no_rd_req", 32'(rd_cnt), 32'(rc));
                o_ready = 1'b1;
            end
        end
        check("last_idx", 32'(last_idx), 32'(exp_last));
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("frame_done_clear", 32'(frame_done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("err_end", 32'(err), 32'd0);
        check("rd_req_count", 32'(rd_cnt - rd0), 32'(cnt));
        check("xf_start_count", 32'(xs_cnt - xs0), 32'(cnt));
        check("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        int          t;
        int          stall;
        int          lat;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, rd0, fd0;
        vecs[0] = '{16'd5,     16'd3, 62, -1, 1, 16'd7};
        vecs[1] = '{16'd100,   16'd2, 10,  1, 2, 16'd101};
        vecs[2] = '{16'hFFFF,  16'd2,  5, -1, 1, 16'h0000};
        vecs[3] = '{16'd40,    16'd1,  3,  0, 3, 16'd40};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_xf_start", 32'(xf_start), 32'd0);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_x", o_x, 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            model_t = vecs[i].t;
            mem_lat = vecs[i].lat;
            run_frame(vecs[i].base, vecs[i].count, vecs[i].stall, vecs[i].exp_last);
        end

        // Zero-length frame: only a frame_done pulse.
        rd0 = rd_cnt; fd0 = fd_cnt;
        go = 1'b1; vtx_base = 16'd12; vtx_count = 16'd0;
        @(negedge clk);
        go = 1'b0;
        check("cnt0_frame_done", 32'(frame_done), 32'd1);
        check("cnt0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("cnt0_frame_done_clear", 32'(frame_done), 32'd0);
        check("cnt0_busy2", 32'(busy), 32'd0);
        check("cnt0_no_rd_req", 32'(rd_cnt - rd0), 32'd0);

        // Timeout: unit accepts start but never returns done.
        hang = 1'b1; model_t = 5; mem_lat = 1; fd0 = fd_cnt;
        go = 1'b1; vtx_base = 16'd3; vtx_count = 16'd1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!xf_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", 32'(xf_start), 32'd1);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        // Two handshake cycles (start, fall seen) then 128 cycles in WAIT_DONE.
        check("to_cycles", 32'(n), 32'd130);
        check("to_busy", 32'(busy), 32'd0);
        check("to_o_valid", 32'(o_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        hang = 1'b0;
        n = 0;
        while (!xf_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_model_idle", 32'(xf_done), 32'd1);
        @(negedge clk);
        run_frame(16'd9, 16'd1, -1, 16'd9);

        // Asynchronous reset while waiting on the transform unit.
        model_t = 62;
        go = 1'b1; vtx_base = 16'd20; vtx_count = 16'd2;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!xf_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_o_valid", 32'(o_valid), 32'd0);
        check("arst_rd_req", 32'(rd_req), 32'd0);
        check("arst_xf_start", 32'(xf_start), 32'd0);
        check("arst_xf_x", xf_x, 32'd0);
        check("arst_o_x", o_x, 32'd0);
        check("arst_o_idx", 32'(o_idx), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("arst_model_still_busy", 32'(xf_done), 32'd0);
        run_frame(16'd7, 16'd1, -1, 16'd7);

        check("start_while_not_done", 32'(start_viol), 32'd0);
        check("operand_stability", 32'(op_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
